fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32: data width in bits, at least 1.
REQ-002 The block SHALL take parameter DEPTH, default 4: output buffer entries, a power of 2, at least 2.
REQ-003 The block SHALL take parameter LINE_LEN, default 640: beats per line, at least 2.
REQ-004 The block SHALL take parameter FRAME_LINES, default 480: lines per frame, at least 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port in_fifo_data, input, WIDTH bits: FIFO read data, valid one cycle after ou_fifo_rden.
REQ-008 The block SHALL have port in_fifo_empty, input, 1 bit: FIFO empty flag.
REQ-009 The block SHALL have port ou_fifo_rden, output, 1 bit: FIFO read enable.
REQ-010 The block SHALL have port in_resync, input, 1 bit: single-cycle pulse that restarts the line and frame counters.
REQ-011 The block SHALL have port ou_result_data, output, WIDTH bits: stream data.
REQ-012 The block SHALL have port ou_result_valid, output, 1 bit: stream valid.
REQ-013 The block SHALL have port in_result_ready, input, 1 bit: stream ready from the downstream consumer.
REQ-014 The block SHALL have port ou_result_last, output, 1 bit: marks the last beat of a line.
REQ-015 The block SHALL have port ou_result_user, output, 1 bit: marks the first beat of a frame.
REQ-016 The block SHALL have port ou_level, output, clog2(DEPTH)+1 bits: current buffer occupancy.

Function
REQ-017 pop SHALL be defined as ou_result_valid AND in_result_ready; a beat transfers only when pop is high.
REQ-018 The block SHALL track pending, a 1-bit flag that is set on the edge after ou_fifo_rden is high and cleared otherwise.
REQ-019 ou_fifo_rden SHALL be combinational and equal to rst AND NOT in_fifo_empty AND (ou_level + pending - pop) < DEPTH.
REQ-020 When pending is high, in_fifo_data SHALL be written to the buffer tail on that edge; no read data is ever dropped.
REQ-021 On each edge, ou_level SHALL change by (+1 if pending) and (-1 if pop); a simultaneous write and pop SHALL leave ou_level unchanged.
REQ-022 ou_result_valid SHALL equal (ou_level != 0); ou_result_data SHALL be the buffer head, and all zeros when ou_result_valid is low.
REQ-023 Latency SHALL be: rden asserted in cycle t, data captured at the end of cycle t+1, ou_result_valid high in cycle t+2.
REQ-024 With in_result_ready held high and the FIFO non-empty, the block SHALL sustain one beat per cycle for DEPTH of 2 or more.
REQ-025 While ou_result_valid is high and in_result_ready is low, ou_result_data, ou_result_last and ou_result_user SHALL hold stable.
REQ-026 The buffer SHALL be a circular buffer with wr_ptr and rd_ptr of clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-027 The full condition SHALL be ou_level == DEPTH and empty SHALL be ou_level == 0; writing to a full buffer is impossible by construction of REQ-019.
REQ-028 The column counter col (0..LINE_LEN-1) SHALL increment on pop; at LINE_LEN-1 it SHALL wrap to 0 and advance row.
REQ-029 The row counter row (0..FRAME_LINES-1) SHALL wrap to 0 after FRAME_LINES-1.
REQ-030 ou_result_last SHALL equal ou_result_valid AND (col == LINE_LEN-1).
REQ-031 ou_result_user SHALL equal ou_result_valid AND (col == 0) AND (row == 0).
REQ-032 When in_resync is high on an edge, col and row SHALL become 0, overriding any same-cycle pop increment; buffer contents and ou_level SHALL be unaffected.

Reset
REQ-033 When rst is low on an edge, ou_level, pending, wr_ptr, rd_ptr, col and row SHALL become 0.
REQ-034 While rst is low, ou_fifo_rden, ou_result_valid, ou_result_last and ou_result_user SHALL be 0 and ou_result_data SHALL be all zeros.
REQ-035 A reset applied mid-stream SHALL discard buffered and pending data; the FIFO read in flight is lost by definition.
REQ-036 Buffer storage RAM SHALL NOT require a reset.

Structure
REQ-037 The shared package SHALL hold the camera constants DEF_LINE_LEN = 640 and DEF_FRAME_LINES = 480, plus the clog2-derived counter widths.
REQ-038 The circular buffer (storage, pointers, level) SHALL be a sub-module named stream_ring_buffer; the top level holds only the rden/pending control and the line/frame counters.

Verification
REQ-039 Reset with DEPTH=4: hold rst low 3 cycles with FIFO non-empty -> rden=0, valid=0, level=0 throughout; first rden occurs in the first cycle with rst high.
REQ-040 Full throughput: 16 words 0..15, ready=1 -> outputs 0..15 in consecutive cycles, first valid 2 cycles after first rden, level never exceeds 2.
REQ-041 Backpressure: ready=0 for 10 cycles -> level saturates at 4, rden=0 once level+pending=4, head data stable; release ready -> 4 words drained in order, none lost or duplicated.
REQ-042 Framing with LINE_LEN=4, FRAME_LINES=2: 8 beats -> last on beats 3 and 7, user on beat 0 only; beat 8 has user=1 again.
REQ-043 Resync: pulse in_resync coincident with the pop of beat 2 -> next beat has col=0 with user=1; data order is preserved.
REQ-044 Mid-stream reset: assert rst with level=3 and pending=1 -> level=0 on the next edge and no stale data appears after release.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the camera stream reader: default frame geometry
// and the counter widths derived from it.
package fifo_stream_reader_pkg;

   localparam int DEF_LINE_LEN    = 640;
   localparam int DEF_FRAME_LINES = 480;

   // Counter width for a range of n values; a single-value range still needs one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_COL_W = cnt_width(DEF_LINE_LEN);
   localparam int DEF_ROW_W = cnt_width(DEF_FRAME_LINES);

endpackage

// File: rtl/stream_ring_buffer.sv
// Circular output buffer: power-of-2 storage with wrapping read/write
// pointers and an occupancy count. Storage itself is never reset.
module stream_ring_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         level <= level + LVL_W'(wr_en) - LVL_W'(rd_en);
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a read-latency-1 FIFO into a ready/valid stream, tagging
// end-of-line (last) and start-of-frame (user) beats.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int LINE_LEN    = DEF_LINE_LEN,
   parameter int FRAME_LINES = DEF_FRAME_LINES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_fifo_data,
   input  logic                     in_fifo_empty,
   output logic                     ou_fifo_rden,
   input  logic                     in_resync,
   output logic [WIDTH-1:0]         ou_result_data,
   output logic                     ou_result_valid,
   input  logic                     in_result_ready,
   output logic                     ou_result_last,
   output logic                     ou_result_user,
   output logic [$clog2(DEPTH):0]   ou_level
);

   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int COL_W = cnt_width(LINE_LEN);
   localparam int ROW_W = cnt_width(FRAME_LINES);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_LINES - 1);
   localparam logic [LVL_W:0]   DEPTH_C  = (LVL_W + 1)'(DEPTH);

   logic             pending;
   logic             pop;
   logic             valid;
   logic [WIDTH-1:0] head;
   logic [LVL_W:0]   projected;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;

   stream_ring_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ring (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (pending),
      .wr_data (in_fifo_data),
      .rd_en   (pop),
      .rd_data (head),
      .level   (ou_level)
   );

   // Count the in-flight read as occupied so the buffer can never overflow.
   assign projected    = {1'b0, ou_level} + {{LVL_W{1'b0}}, pending} - {{LVL_W{1'b0}}, pop};
   assign ou_fifo_rden = rst && !in_fifo_empty && (projected < DEPTH_C);

   assign valid           = rst && (ou_level != '0);
   assign pop             = valid && in_result_ready;
   assign ou_result_valid = valid;
   assign ou_result_data  = valid ? head : '0;
   assign ou_result_last  = valid && (col == COL_LAST);
   assign ou_result_user  = valid && (col == '0) && (row == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending <= 1'b0;
      end else begin
         pending <= ou_fifo_rden;
      end
   end

   // Resync wins over a same-cycle pop so the next beat starts a fresh frame.
   always_ff @(posedge clk) begin
      if (!rst || in_resync) begin
         col <= '0;
         row <= '0;
      end else if (pop) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small line/frame geometry
// and a behavioural read-latency-1 FIFO in front of it.
module tb_fifo_stream_reader;

   localparam int WIDTH       = 16;
   localparam int DEPTH       = 4;
   localparam int LINE_LEN    = 4;
   localparam int FRAME_LINES = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [WIDTH-1:0]  in_fifo_data;
   logic              in_fifo_empty;
   logic              ou_fifo_rden;
   logic              in_resync;
   logic [WIDTH-1:0]  ou_result_data;
   logic              ou_result_valid;
   logic              in_result_ready;
   logic              ou_result_last;
   logic              ou_result_user;
   logic [2:0]        ou_level;

   logic [WIDTH-1:0]  fifo_mem [64];
   int                fifo_wr = 0;
   int                fifo_rd = 0;

   int                pass_cnt  = 0;
   int                check_cnt = 0;
   int                col_m = 0;
   int                row_m = 0;

   always #5 clk = ~clk;

   fifo_stream_reader #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .LINE_LEN    (LINE_LEN),
      .FRAME_LINES (FRAME_LINES)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_fifo_data    (in_fifo_data),
      .in_fifo_empty   (in_fifo_empty),
      .ou_fifo_rden    (ou_fifo_rden),
      .in_resync       (in_resync),
      .ou_result_data  (ou_result_data),
      .ou_result_valid (ou_result_valid),
      .in_result_ready (in_result_ready),
      .ou_result_last  (ou_result_last),
      .ou_result_user  (ou_result_user),
      .ou_level        (ou_level)
   );

   // Source FIFO: read data appears one cycle after the enable.
   assign in_fifo_empty = (fifo_rd == fifo_wr);

   always @(posedge clk) begin
      if (ou_fifo_rden) begin
         in_fifo_data <= fifo_mem[fifo_rd[5:0]];
         fifo_rd      <= fifo_rd + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_word(input logic [WIDTH-1:0] v);
      fifo_mem[fifo_wr[5:0]] = v;
      fifo_wr++;
   endtask

   task automatic check_beat(input string tag, input logic [WIDTH-1:0] exp_data, input bit resync_now);
      check({tag, "_valid"}, 32'(ou_result_valid), 32'd1);
      check({tag, "_data"},  32'(ou_result_data),  32'(exp_data));
      check({tag, "_last"},  32'(ou_result_last),  32'(col_m == LINE_LEN - 1));
      check({tag, "_user"},  32'(ou_result_user),  32'(col_m == 0 && row_m == 0));
      if (resync_now) begin
         col_m = 0;
         row_m = 0;
      end else if (col_m == LINE_LEN - 1) begin
         col_m = 0;
         row_m = (row_m + 1) % FRAME_LINES;
      end else begin
         col_m++;
      end
   endtask

   initial begin
      rst             = 1'b0;
      in_resync       = 1'b0;
      in_result_ready = 1'b1;
      for (int i = 0; i < 16; i++) push_word(WIDTH'(i));

      // Reset held with a non-empty FIFO
      repeat (3) begin
         @(negedge clk);
         check("rst_rden",  32'(ou_fifo_rden),    32'd0);
         check("rst_valid", 32'(ou_result_valid), 32'd0);
         check("rst_level", 32'(ou_level),        32'd0);
         check("rst_data",  32'(ou_result_data),  32'd0);
         check("rst_user",  32'(ou_result_user),  32'd0);
      end

      @(negedge clk);
      rst = 1'b1;
      #1;
      check("first_rden", 32'(ou_fifo_rden), 32'd1);
      @(negedge clk);
      check("lat_valid", 32'(ou_result_valid), 32'd0);

      // Full throughput, also exercising line/frame tagging
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check_beat("tput", WIDTH'(i), 1'b0);
         check("tput_level", 32'(ou_level), 32'd1);
      end
      @(negedge clk);
      check("tput_end_valid", 32'(ou_result_valid), 32'd0);
      check("tput_end_level", 32'(ou_level),        32'd0);

      // Backpressure
      in_result_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_word(WIDTH'(100 + i));
      #1;
      check("bp_rden0", 32'(ou_fifo_rden), 32'd1);
      for (int c = 1; c < 10; c++) begin
         @(negedge clk);
         check("bp_level", 32'(ou_level),     32'((c <= 1) ? 0 : ((c - 1 > 4) ? 4 : c - 1)));
         check("bp_rden",  32'(ou_fifo_rden), 32'(c <= 3));
         if (c >= 2) begin
            check("bp_hold_data", 32'(ou_result_data), 32'd100);
            check("bp_hold_user", 32'(ou_result_user), 32'd1);
         end
      end
      @(negedge clk);
      in_result_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check_beat("drain", WIDTH'(100 + k), 1'b0);
         @(negedge clk);
      end
      check("drain_end_valid", 32'(ou_result_valid), 32'd0);
      check("drain_end_level", 32'(ou_level),        32'd0);

      // Resync on the pop of the third beat
      for (int i = 0; i < 8; i++) push_word(WIDTH'(20 + i));
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         in_resync = (k == 2);
         check_beat("resync", WIDTH'(20 + k), k == 2);
         @(negedge clk);
      end
      in_resync = 1'b0;
      check("resync_end_valid", 32'(ou_result_valid), 32'd0);

      // Reset while buffer holds 3 words and a read is in flight
      in_result_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_word(WIDTH'(40 + i));
      repeat (4) @(negedge clk);
      check("mid_pre_level", 32'(ou_level),     32'd3);
      check("mid_pre_rden",  32'(ou_fifo_rden), 32'd0);
      rst = 1'b0;
      #1;
      check("mid_rst_rden",  32'(ou_fifo_rden),    32'd0);
      check("mid_rst_valid", 32'(ou_result_valid), 32'd0);
      check("mid_rst_data",  32'(ou_result_data),  32'd0);
      @(negedge clk);
      check("mid_rst_level", 32'(ou_level), 32'd0);
      rst             = 1'b1;
      in_result_ready = 1'b1;
      col_m           = 0;
      row_m           = 0;
      #1;
      check("mid_rel_rden", 32'(ou_fifo_rden), 32'd1);
      @(negedge clk);
      check("mid_no_stale", 32'(ou_result_valid), 32'd0);
      @(negedge clk);
      check_beat("mid_after", WIDTH'(44), 1'b0);
      @(negedge clk);
      check_beat("mid_after", WIDTH'(45), 1'b0);
      @(negedge clk);
      check("mid_end_valid", 32'(ou_result_valid), 32'd0);
      check("mid_end_level", 32'(ou_level),        32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
